fast_square_freq_stepper: RTL
=============================

# fast_square_freq_stepper

Synthesizer-side responder for the fast-square frequency-sweep handshake. Accepts step-reset and step requests from the sweep controller, computes the next synthesizer tuning word, shifts it into the external PLL chip over a 3-wire serial bus, and waits for the chip's lock-detect to settle. It then raises `pll_locked` to tell the controller to start recording. It sits between the sweep controller and the synthesizer pins.

## Interface

Parameters:
- `NUM_FREQ_STEPS`, 100: number of sweep points. Step index runs 0..NUM_FREQ_STEPS-1.
- `BASE_WORD`, 24'h1F4000: tuning word for index 0.
- `STEP_WORD`, 24'h000100: tuning-word increment per step.
- `SPI_DIV`, 4: clocks per serial-clock half-period (≥1).
- `SETTLE_TICKS`, 2000: consecutive synchronized lock-detect-high cycles required before lock is declared (≥1).
- `LOCK_TIMEOUT`, 65535: maximum cycles spent in SETTLE before giving up.

Ports:
- `clock`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-low (0 = reset).
- `freq_step_reset_in`  in  1: level from controller. Its rising edge restarts the sweep at index 0.
- `freq_step_in`  in  1: level from controller. Its rising edge advances one step.
- `lock_detect`  in  1: asynchronous lock-detect pin from the synthesizer.
- `pll_locked`  out  1: high when the programmed frequency is settled.
- `spi_sclk`  out  1: serial clock, idles low.
- `spi_mosi`  out  1: serial data, MSB first.
- `spi_le`  out  1: latch-enable pulse after the last bit.
- `step_index`  out  8: index currently programmed or being programmed.
- `tune_error`  out  1: sticky flag, set on lock timeout.

## Operation

- Inputs `freq_step_reset_in` and `freq_step_in` each pass through an edge detector. The previous-value registers reset to 0, so an input that is already high after reset counts as an edge.
- `lock_detect` passes through a 2-flop synchronizer.
- States:
  - IDLE: waiting after reset.
  - LOAD: latch the word into the shift register.
  - SHIFT: serialize the word.
  - LATCH: pulse `spi_le`.
  - SETTLE: count lock-detect-high cycles.
  - LOCKED: frequency settled.
- IDLE: `pll_locked`=0. Only a reset edge leaves this state (to LOAD). Step edges are ignored.
- Reset edge, in any state:
  - Set index←0, word←BASE_WORD, clear `tune_error`, go to LOAD.
  - Any transfer in progress is aborted: `spi_sclk`=0 and `spi_le`=0 immediately.
- Step edge in LOCKED:
  - If index=NUM_FREQ_STEPS-1, set index←0 and word←BASE_WORD.
  - Otherwise set index←index+1 and word←word+STEP_WORD, modulo 2^24.
  - Go to LOAD.
- Step edge outside LOCKED is ignored.
- Reset edge and step edge in the same cycle: the reset edge wins.
- LOAD: 1 cycle; copy the word into the 24-bit shift register.
- SHIFT: 24 bits, MSB first. Each bit:
  - `spi_mosi` takes the bit value, with `spi_sclk`=0, for SPI_DIV cycles.
  - Then `spi_sclk`=1 for SPI_DIV cycles.
  - `spi_mosi` changes only while `spi_sclk` is low.
- LATCH: `spi_sclk`=0, `spi_le`=1 for SPI_DIV cycles, then go to SETTLE.
- SETTLE:
  - The counter increments on each cycle with synchronized lock-detect high and clears to 0 on any low cycle.
  - When the counter reaches SETTLE_TICKS, go to LOCKED.
  - If LOCK_TIMEOUT cycles elapse in SETTLE first, set `tune_error` and go to LOCKED anyway, so the controller cannot hang.
- LOCKED: `pll_locked`=1.
- `pll_locked` is registered, and is high only in LOCKED.
- Lock-detect loss while in LOCKED is ignored.

## Timing

- Reset values:
  - `pll_locked`, `spi_sclk`, `spi_mosi`, `spi_le`, `tune_error`: 0.
  - `step_index`: 0.
  - State: IDLE.
  - Word: BASE_WORD.
- Request edge sampled in cycle N:
  - `pll_locked`=0 from cycle N+1.
  - `step_index` updated in cycle N+1.
- Transfer (LOAD + SHIFT + LATCH) takes 1+49·SPI_DIV cycles.
- With lock-detect held high, `pll_locked` rises exactly 2+49·SPI_DIV+SETTLE_TICKS cycles after the edge cycle N.
- Reset asserted mid-transfer forces all outputs to their reset values asynchronously.

## Test plan

- Reset release with `freq_step_reset_in`=1, `lock_detect`=1, SPI_DIV=4, SETTLE_TICKS=16:
  - 24 bits shifted equal 24'h1F4000, MSB first.
  - One `spi_le` pulse of 4 cycles.
  - `pll_locked` rises 214 cycles after the edge.
  - `step_index`=0.
- Three step edges, each issued after `pll_locked` rises:
  - Shifted words are 24'h1F4100, 24'h1F4200, 24'h1F4300.
  - `step_index`=3.
  - `pll_locked` falls 1 cycle after each edge.
- NUM_FREQ_STEPS=4, five step edges:
  - Index sequence 1,2,3,0,1.
  - The word after the wrap equals BASE_WORD.
- Reset edge at bit 10 of a transfer:
  - `spi_sclk` returns low the next cycle.
  - A fresh 24-bit transfer of BASE_WORD follows, and no `spi_le` pulse occurs for the aborted word.
- `lock_detect` toggling every 8 cycles, SETTLE_TICKS=16, LOCK_TIMEOUT=500:
  - `tune_error`=1 and `pll_locked`=1 after 500 SETTLE cycles.
  - The next reset edge clears `tune_error`.
- Step edge while in SHIFT, and reset+step edges in the same cycle:
  - The step-only edge is ignored and the transfer completes unchanged.
  - For the simultaneous case, index=0 and BASE_WORD is shifted.

Source files
------------

// File: rtl/fast_square_freq_stepper.sv
// fast_square_freq_stepper
//   Synthesizer-side responder for the fast-square sweep handshake. A rising
//   edge on freq_step_reset_in restarts the sweep at index 0. A rising edge on
//   freq_step_in, accepted only while locked, advances one step. Either edge
//   computes the tuning word, shifts it MSB first into the PLL chip, pulses
//   the latch enable and waits for lock-detect to stay high long enough. Then
//   pll_locked is raised.
//
// Ports
//   clock, reset           : clock, asynchronous active-low reset
//   freq_step_reset_in     : level, rising edge restarts the sweep
//   freq_step_in           : level, rising edge advances one step (LOCKED only)
//   lock_detect            : asynchronous lock-detect pin from the synthesizer
//   pll_locked             : registered, high only in LOCKED
//   spi_sclk/mosi/le       : 3-wire serial bus to the PLL chip
//   step_index [7:0]       : index programmed or being programmed
//   tune_error             : sticky lock-timeout flag, cleared by a reset edge
module fast_square_freq_stepper #(
   parameter int unsigned NUM_FREQ_STEPS = 100,
   parameter logic [23:0] BASE_WORD      = 24'h1F4000,
   parameter logic [23:0] STEP_WORD      = 24'h000100,
   parameter int unsigned SPI_DIV        = 4,
   parameter int unsigned SETTLE_TICKS   = 2000,
   parameter int unsigned LOCK_TIMEOUT   = 65535
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       freq_step_reset_in,
   input  logic       freq_step_in,
   input  logic       lock_detect,
   output logic       pll_locked,
   output logic       spi_sclk,
   output logic       spi_mosi,
   output logic       spi_le,
   output logic [7:0] step_index,
   output logic       tune_error
);

   localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
   localparam int SET_W = $clog2(SETTLE_TICKS + 1);
   localparam int TMO_W = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);
   localparam logic [SET_W-1:0] SET_DONE = SET_W'(SETTLE_TICKS);
   localparam logic [TMO_W-1:0] TMO_DONE = TMO_W'(LOCK_TIMEOUT);
   localparam logic [7:0]       IDX_LAST = 8'(NUM_FREQ_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_SETTLE, S_LOCKED
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        idx_q, idx_d;
   logic [23:0]       word_q, word_d;
   logic [23:0]       shreg_q, shreg_d;
   logic [4:0]        bit_q, bit_d;
   logic              half_q, half_d;     // 0: sclk low half, 1: sclk high half
   logic [DIV_W-1:0]  div_q, div_d;
   logic [SET_W-1:0]  set_q, set_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;
   logic              locked_q, locked_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              le_q, le_d;
   logic              rst_prev_q, step_prev_q;
   logic              sync1_q, sync2_q;

   logic rst_edge, step_edge;

   // Previous-value flops reset to 0: a level already high after reset is an edge.
   assign rst_edge  = freq_step_reset_in & ~rst_prev_q;
   assign step_edge = freq_step_in & ~step_prev_q;

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         word_q      <= BASE_WORD;
         shreg_q     <= '0;
         bit_q       <= '0;
         half_q      <= 1'b0;
         div_q       <= '0;
         set_q       <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         locked_q    <= 1'b0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         le_q        <= 1'b0;
         rst_prev_q  <= 1'b0;
         step_prev_q <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         shreg_q     <= shreg_d;
         bit_q       <= bit_d;
         half_q      <= half_d;
         div_q       <= div_d;
         set_q       <= set_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         locked_q    <= locked_d;
         sclk_q      <= sclk_d;
         mosi_q      <= mosi_d;
         le_q        <= le_d;
         rst_prev_q  <= freq_step_reset_in;
         step_prev_q <= freq_step_in;
         sync1_q     <= lock_detect;
         sync2_q     <= sync1_q;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      half_d  = half_q;
      div_d   = div_q;
      set_d   = set_q;
      tmo_d   = tmo_q;
      err_d   = err_q;

      case (state_q)
         S_LOAD: begin
            shreg_d = word_q;
            bit_d   = '0;
            half_d  = 1'b0;
            div_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  // End of a bit: the next MSB moves into shreg[23].
                  half_d  = 1'b0;
                  shreg_d = {shreg_q[22:0], 1'b0};
                  if (bit_q == 5'd23) state_d = S_LATCH;
                  else                bit_d   = bit_q + 5'd1;
               end
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_LATCH: begin
            if (div_q == DIV_LAST) begin
               div_d   = '0;
               set_d   = '0;
               tmo_d   = '0;
               state_d = S_SETTLE;
            end else begin
               div_d = div_q + DIV_W'(1);
            end
         end
         S_SETTLE: begin
            tmo_d = tmo_q + TMO_W'(1);
            set_d = sync2_q ? set_q + SET_W'(1) : '0;
            // A lock reached on the timeout cycle counts as a clean lock.
            if (set_d == SET_DONE) begin
               state_d = S_LOCKED;
            end else if (tmo_d == TMO_DONE) begin
               err_d   = 1'b1;
               state_d = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (step_edge) begin
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  word_d = BASE_WORD;
               end else begin
                  idx_d  = idx_q + 8'd1;
                  word_d = word_q + STEP_WORD;
               end
               state_d = S_LOAD;
            end
         end
         default: ;  // IDLE waits for a reset edge
      endcase

      // Reset edge wins over everything, including a simultaneous step edge.
      if (rst_edge) begin
         idx_d   = '0;
         word_d  = BASE_WORD;
         err_d   = 1'b0;
         state_d = S_LOAD;
      end
   end

   // Outputs are registered from the next-state values so an abort drops
   // sclk/le on the very next cycle.
   always_comb begin
      locked_d = (state_d == S_LOCKED);
      sclk_d   = (state_d == S_SHIFT) && half_d;
      le_d     = (state_d == S_LATCH);
      // mosi only moves at the start of a low half, otherwise holds.
      mosi_d   = ((state_d == S_SHIFT) && !half_d) ? shreg_d[23] : mosi_q;
   end

   assign pll_locked = locked_q;
   assign spi_sclk   = sclk_q;
   assign spi_mosi   = mosi_q;
   assign spi_le     = le_q;
   assign step_index = idx_q;
   assign tune_error = err_q;

endmodule
